// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program store, program counter and a three-state
// sequencer (IDLE / FETCH / VALID) that presents one registered instruction
// to the control FSM at a time and exposes the PC on a tri-state bus tap.
module instr_fetch_unit #(
  parameter int ADDR_W  = 6,
  parameter int INSTR_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done,
  input  logic               branch,
  input  logic [ADDR_W-1:0]  branchaddress,
  input  logic               export_pc,
  inout  wire  [ADDR_W-1:0]  out_pc,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  pc_d;
  logic               instr_ld;
  logic               vld_d;
  logic [INSTR_W-1:0] instr_p1;
  logic               vld_p1;
  logic [INSTR_W-1:0] mem [DEPTH];

  // Sequential PC step; the adder width makes the top address wrap to 0.
  function automatic logic [ADDR_W-1:0] pc_step(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(1);
  endfunction

  // Program store write port: loadable in any state, never cleared by reset
  // so a program survives a mid-run reset.
  always_ff @(posedge clk) begin
    if (prog_we) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Control registers: sequencer state and program counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next-state, next-PC and fetch strobe. Branch always takes priority over
  // done; a branch seen during FETCH retargets the fetch instead of loading.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_ld = 1'b0;
    vld_d    = vld_p1;
    case (state_q)
      ST_IDLE: begin
        vld_d = 1'b0;
        if (!prog_we) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (branch) begin
          pc_d = branchaddress;
        end else begin
          instr_ld = 1'b1;
          vld_d    = 1'b1;
          state_d  = ST_VALID;
        end
      end
      ST_VALID: begin
        if (branch) begin
          pc_d    = branchaddress;
          vld_d   = 1'b0;
          state_d = ST_FETCH;
        end else if (done) begin
          pc_d    = pc_step(pc_q);
          vld_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      default: begin
        vld_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage p1: registered read of mem[pc]. The read samples the array before
  // any same-edge write lands, so a colliding write returns the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_p1 <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= vld_d;
      if (instr_ld) begin
        instr_p1 <= mem[pc_q];
      end
    end
  end

  assign instruction = instr_p1;
  assign instr_valid = vld_p1;

  // PC bus tap: purely combinational, released when not exporting.
  assign out_pc = export_pc ? pc_q : {ADDR_W{1'bz}};

  // The valid flag is exactly "sitting in VALID".
  a_vld_state : assert property (@(posedge clk) disable iff (!rst)
    vld_p1 == (state_q == ST_VALID));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random program contents and random
// done/branch/write traffic, checked against a transaction-level model
// (program array, expected PC and expected held instruction).
module tb_instr_fetch_unit;

  localparam int ADDR_W  = 6;
  localparam int INSTR_W = 10;
  localparam int DEPTH   = 1 << ADDR_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               done;
  logic               branch;
  logic [ADDR_W-1:0]  branchaddress;
  logic               export_pc;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [INSTR_W-1:0] instruction;
  logic               instr_valid;
  wire  [ADDR_W-1:0]  out_pc;

  // Bench-side driver on the shared bus, used to probe high impedance.
  logic               bus_en;
  logic [ADDR_W-1:0]  bus_val;
  assign out_pc = bus_en ? bus_val : {ADDR_W{1'bz}};

  // Reference model state
  logic [INSTR_W-1:0] mem_m [DEPTH];
  logic [ADDR_W-1:0]  pc_m;
  logic [INSTR_W-1:0] instr_m;

  int n_chk = 0;
  int n_err = 0;

  instr_fetch_unit #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .done          (done),
    .branch        (branch),
    .branchaddress (branchaddress),
    .export_pc     (export_pc),
    .out_pc        (out_pc),
    .prog_we       (prog_we),
    .prog_addr     (prog_addr),
    .prog_data     (prog_data),
    .instruction   (instruction),
    .instr_valid   (instr_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] model_inc(input logic [ADDR_W-1:0] pc);
    return ADDR_W'((int'(pc) + 1) % DEPTH);
  endfunction

  // One control event issued in VALID; expects the new instruction two
  // edges after the event is raised.
  task automatic do_op(input string tag, input logic d, input logic b,
                       input logic [ADDR_W-1:0] a);
    int edges;
    done = d;
    branch = b;
    branchaddress = a;
    step();
    done = 1'b0;
    branch = 1'b0;
    branchaddress = ADDR_W'($urandom);
    pc_m = b ? a : model_inc(pc_m);
    instr_m = mem_m[pc_m];
    edges = 1;
    while (!instr_valid && edges < 6) begin
      step();
      edges++;
    end
    chk({tag, "_lat"}, 32'(edges), 32'd2);
    chk({tag, "_instr"}, 32'(instruction), 32'(instr_m));
    chk({tag, "_pc"}, 32'(out_pc), 32'(pc_m));
  endtask

  initial begin
    logic [INSTR_W-1:0] nw;
    logic [INSTR_W-1:0] old;
    logic [ADDR_W-1:0]  a;
    int r;

    done = 1'b0; branch = 1'b0; branchaddress = '0;
    export_pc = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    bus_en = 1'b0; bus_val = '0;
    rst = 1'b1;
    #2 rst = 1'b0;

    // Reset held while control inputs toggle
    for (int i = 0; i < 4; i++) begin
      done = 1'($urandom);
      branch = 1'($urandom);
      branchaddress = ADDR_W'($urandom);
      step();
    end
    chk("rst_instr", 32'(instruction), 32'h000);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    export_pc = 1'b0; bus_en = 1'b1; bus_val = 6'h2D;
    #1;
    chk("rst_bus_z", 32'(out_pc), 32'h2D);
    bus_en = 1'b0; export_pc = 1'b1;

    // Program load: fixed first three words, random rest
    for (int i = 0; i < DEPTH; i++) mem_m[i] = INSTR_W'($urandom);
    mem_m[0] = 10'h041; mem_m[1] = 10'h092; mem_m[2] = 10'h1A3;
    prog_we = 1'b1; prog_addr = '0; prog_data = mem_m[0];
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      prog_addr = ADDR_W'(i);
      prog_data = mem_m[i];
      done = 1'($urandom);
      branch = 1'($urandom);
      branchaddress = ADDR_W'($urandom);
      step();
    end
    prog_we = 1'b0; done = 1'b0; branch = 1'b0;
    pc_m = '0;
    step();
    chk("load_e1_valid", 32'(instr_valid), 32'd0);
    step();
    instr_m = mem_m[0];
    chk("load_e2_valid", 32'(instr_valid), 32'd1);
    chk("load_instr", 32'(instruction), 32'h041);
    chk("load_pc", 32'(out_pc), 32'd0);

    do_op("done1", 1'b1, 1'b0, '0);
    chk("done1_word", 32'(instruction), 32'h092);
    do_op("done2", 1'b1, 1'b0, '0);
    chk("done2_word", 32'(instruction), 32'h1A3);

    // Branch to top and wrap
    do_op("br63", 1'b0, 1'b1, 6'h3F);
    do_op("wrap", 1'b1, 1'b0, '0);
    chk("wrap_pc0", 32'(out_pc), 32'd0);

    // Simultaneous events: branch wins
    do_op("both", 1'b1, 1'b1, 6'h05);
    chk("both_pc5", 32'(out_pc), 32'd5);

    // Bus tap
    do_op("br2", 1'b0, 1'b1, 6'h02);
    chk("bus_on", 32'(out_pc), 32'h02);
    export_pc = 1'b0; bus_en = 1'b1; bus_val = 6'h2D;
    #1;
    chk("bus_off", 32'(out_pc), 32'h2D);
    bus_en = 1'b0; export_pc = 1'b1;
    #1;

    // Hold in VALID while rewriting the held word
    old = instr_m;
    for (int i = 0; i < 3; i++) begin
      prog_we = 1'b1; prog_addr = pc_m; prog_data = INSTR_W'($urandom);
      step();
      mem_m[pc_m] = prog_data;
      chk("hold_instr", 32'(instruction), 32'(old));
      chk("hold_valid", 32'(instr_valid), 32'd1);
    end
    prog_we = 1'b0;
    chk("hold_pc", 32'(out_pc), 32'(pc_m));

    // Branch during FETCH retargets the fetch
    done = 1'b1; step(); done = 1'b0;
    pc_m = model_inc(pc_m);
    a = ADDR_W'($urandom);
    branch = 1'b1; branchaddress = a; step(); branch = 1'b0;
    pc_m = a;
    chk("fb_valid", 32'(instr_valid), 32'd0);
    chk("fb_pc", 32'(out_pc), 32'(a));
    chk("fb_instr_kept", 32'(instruction), 32'(instr_m));
    step();
    instr_m = mem_m[pc_m];
    chk("fb_valid2", 32'(instr_valid), 32'd1);
    chk("fb_instr", 32'(instruction), 32'(instr_m));

    // done held through FETCH is ignored there
    done = 1'b1; step(); step(); done = 1'b0;
    pc_m = model_inc(pc_m);
    instr_m = mem_m[pc_m];
    chk("fd_pc", 32'(out_pc), 32'(pc_m));
    chk("fd_valid", 32'(instr_valid), 32'd1);
    chk("fd_instr", 32'(instruction), 32'(instr_m));

    // Read-first: write the target word on the fetch edge
    done = 1'b1; step(); done = 1'b0;
    pc_m = model_inc(pc_m);
    old = mem_m[pc_m];
    nw = ~old;
    prog_we = 1'b1; prog_addr = pc_m; prog_data = nw;
    step();
    prog_we = 1'b0;
    chk("rf_instr_old", 32'(instruction), 32'(old));
    mem_m[pc_m] = nw;
    instr_m = old;
    do_op("rf_refetch", 1'b0, 1'b1, pc_m);

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      r = int'($urandom_range(0, 3));
      a = ADDR_W'($urandom);
      case (r)
        0: do_op("rnd_done", 1'b1, 1'b0, a);
        1: do_op("rnd_br", 1'b0, 1'b1, a);
        2: do_op("rnd_both", 1'b1, 1'b1, a);
        default: begin
          prog_we = 1'b1; prog_addr = a; prog_data = INSTR_W'($urandom);
          step();
          prog_we = 1'b0;
          mem_m[a] = prog_data;
          chk("rnd_hold", 32'(instruction), 32'(instr_m));
        end
      endcase
    end

    // Asynchronous reset in VALID with done pending
    done = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(instr_valid), 32'd0);
    chk("arst_instr", 32'(instruction), 32'h000);
    chk("arst_pc", 32'(out_pc), 32'd0);
    step();
    chk("arst_edge_pc", 32'(out_pc), 32'd0);
    done = 1'b0;
    rst = 1'b1;
    pc_m = '0;
    step();
    chk("rel_e1_valid", 32'(instr_valid), 32'd0);
    step();
    instr_m = mem_m[0];
    chk("rel_e2_valid", 32'(instr_valid), 32'd1);
    chk("rel_instr", 32'(instruction), 32'(instr_m));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
